// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM port arbiter.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_LDR = 1;

  // SRAM OE/WE are active-low; this is their idle level.
  localparam logic STROBE_INACTIVE = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshake and SRAM pin bundle for sram_arbiter.
// Optional build macro: SRAM_ARB_STATS_EN adds the acc_cnt0/acc_cnt1 counters.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              OE;
  logic              WE;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]       acc_cnt0;
  logic [15:0]       acc_cnt1;
`endif

  // Requesters plus the SRAM device model.
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, Data_from_SRAM,
    input  gnt, done, rdata, busy, ADDR, Data_to_SRAM, OE, WE
`ifdef SRAM_ARB_STATS_EN
    , input acc_cnt0, acc_cnt1
`endif
  );

  // The arbiter itself.
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, Data_from_SRAM,
    output gnt, done, rdata, busy, ADDR, Data_to_SRAM, OE, WE
`ifdef SRAM_ARB_STATS_EN
    , output acc_cnt0, acc_cnt1
`endif
  );

endinterface

// File: rtl/sram_rr_pick.sv
// Combinational 2-way round-robin pick: on contention the port not granted last wins.
module sram_rr_pick
  import slc3_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       valid_o
);

  // Single requester wins outright; both requesting alternates away from last_i.
  always_comb begin
    valid_o  = |req_i;
    winner_o = 1'(PORT_CPU);
    case (req_i)
      2'b01:   winner_o = 1'(PORT_CPU);
      2'b10:   winner_o = 1'(PORT_LDR);
      2'b11:   winner_o = ~last_i;
      default: winner_o = 1'(PORT_CPU);
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for the single SRAM port (port 0 = CPU, port 1 = loader/DMA).
// Each access holds OE or WE low for WAIT_CYCLES cycles, then pulses done for one cycle.
// Optional build macro: SRAM_ARB_STATS_EN adds per-port completed-access counters.
module sram_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              last_q, last_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;

  logic [1:0]        pick_req;
  logic              pick_win;
  logic              pick_valid;

  // In DONE the finishing port's req is stale (it drops on done), so it is masked out.
  always_comb begin
    pick_req = '0;
    unique case (state_q)
      IDLE:    pick_req = bus.req;
      DONE:    pick_req = bus.req & ~(2'b01 << port_q);
      default: pick_req = '0;
    endcase
  end

  sram_rr_pick u_pick (
    .req_i    (pick_req),
    .last_i   (last_q),
    .winner_o (pick_win),
    .valid_o  (pick_valid)
  );

  // Next-state: grant/latch from IDLE or DONE, count down the strobe window in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    last_d  = last_q;
    op_we_d = op_we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    oe_d    = STROBE_INACTIVE;
    we_d    = STROBE_INACTIVE;

    unique case (state_q)
      IDLE, DONE: begin
        if (pick_valid) begin
          state_d          = ACCESS;
          gnt_d[pick_win]  = 1'b1;
          port_d           = pick_win;
          last_d           = pick_win;
          op_we_d          = bus.we[pick_win];
          addr_d           = pick_win ? bus.addr1 : bus.addr0;
          wdata_d          = pick_win ? bus.wdata1 : bus.wdata0;
          cnt_d            = CntLoad;
          oe_d             = bus.we[pick_win];
          we_d             = ~bus.we[pick_win];
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d        = DONE;
          done_d[port_q] = 1'b1;
          if (!op_we_q) begin
            rdata_d = bus.Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          oe_d  = op_we_q;
          we_d  = ~op_we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All arbiter state and registered SRAM strobes; reset drops OE/WE immediately.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= 1'(PORT_CPU);
      last_q  <= 1'(PORT_LDR);
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      oe_q    <= STROBE_INACTIVE;
      we_q    <= STROBE_INACTIVE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      last_q  <= last_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = wdata_q;
  assign bus.OE           = oe_q;
  assign bus.WE           = we_q;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] acc_cnt0_q;
  logic [15:0] acc_cnt1_q;

  // Count done pulses per port; counters wrap from 0xFFFF to 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_cnt0_q <= '0;
      acc_cnt1_q <= '0;
    end else begin
      if (done_d[0]) acc_cnt0_q <= acc_cnt0_q + 16'd1;
      if (done_d[1]) acc_cnt1_q <= acc_cnt1_q + 16'd1;
    end
  end

  assign bus.acc_cnt0 = acc_cnt0_q;
  assign bus.acc_cnt1 = acc_cnt1_q;
`endif

endmodule
